// File: rtl/juggle_pkg.sv
// Shared types and constants for the juggling throw scheduler.
package juggle_pkg;

  localparam int MAX_HEIGHT = 7;
  localparam int MAX_LEN    = 7;

  typedef logic [2:0] ball_id_t;

  typedef struct packed {
    logic     valid;
    ball_id_t id;
  } landing_slot_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ERROR = 2'd2
  } sched_state_t;

endpackage

// File: rtl/landing_queue.sv
// Height-indexed landing queue: slot i holds the ball landing i beats after the next beat.
// Shifts down on each beat; a write lands in the post-shift array at wr_idx_in.
module landing_queue
  import juggle_pkg::*;
#(
  parameter int DEPTH = MAX_HEIGHT
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          clear_in,
  input  logic          shift_in,
  input  logic          wr_en_in,
  input  logic [2:0]    wr_idx_in,
  input  ball_id_t      wr_id_in,
  output landing_slot_t head_out,
  output logic          occupied_out
);

  landing_slot_t [DEPTH-1:0] slots_q;
  landing_slot_t [DEPTH-1:0] slots_d;
  landing_slot_t [DEPTH-1:0] shifted;
  logic                      idx_ok;

  assign idx_ok   = int'(wr_idx_in) < DEPTH;
  assign head_out = slots_q[0];

  always_comb begin
    shifted = slots_q;
    if (shift_in) begin
      for (int i = 0; i < DEPTH-1; i++) begin
        shifted[i] = slots_q[i+1];
      end
      shifted[DEPTH-1] = '0;
    end
  end

  // An index past the end can never be written, so report it as occupied.
  always_comb begin
    occupied_out = 1'b1;
    if (idx_ok) begin
      occupied_out = shifted[wr_idx_in].valid;
    end
  end

  always_comb begin
    slots_d = shifted;
    if (clear_in) begin
      slots_d = '0;
    end else if (wr_en_in && idx_ok) begin
      slots_d[wr_idx_in].valid = 1'b1;
      slots_d[wr_idx_in].id    = wr_id_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      slots_q <= '0;
    end else begin
      slots_q <= slots_d;
    end
  end

endmodule

// File: rtl/throw_scheduler.sv
// Turns a validated siteswap pattern into registered per-beat throw events.
// Optional THROW_SCHED_STATS_EN adds a saturating emitted-throw counter port.
//
// state | meaning
// IDLE  | no pattern loaded, beats ignored
// RUN   | sequencing the loaded pattern on each new_beat
// ERROR | pattern fault seen; sticky until the next load edge
module throw_scheduler #(
  parameter int MAX_HEIGHT = juggle_pkg::MAX_HEIGHT,
  parameter int MAX_LEN    = juggle_pkg::MAX_LEN,
  parameter bit FIRST_HAND = 1'b0
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     new_beat,
  input  logic [MAX_LEN-1:0][2:0]  pattern_in,
  input  logic [2:0]               pattern_length,
  input  logic [2:0]               num_balls_in,
  input  logic                     pattern_valid_in,
  output logic                     throw_valid_out,
  output logic [2:0]               throw_ball_out,
  output logic [2:0]               throw_height_out,
  output logic                     throw_hand_out,
  output logic [2:0]               pattern_pos_out,
  output logic                     running_out,
`ifdef THROW_SCHED_STATS_EN
  output logic [15:0]              throw_count_out,
`endif
  output logic                     error_out
);
  import juggle_pkg::*;

  sched_state_t             state_q, state_d;
  logic                     pv_q, pv_d;
  logic [MAX_LEN-1:0][2:0]  pat_q, pat_d;
  logic [2:0]               len_q, len_d;
  logic [2:0]               balls_q, balls_d;
  logic [2:0]               pos_q, pos_d;
  logic                     hand_q, hand_d;
  ball_id_t                 intro_q, intro_d;
  logic                     valid_q, valid_d;
  ball_id_t                 ball_q, ball_d;
  logic [2:0]               height_q, height_d;
  logic                     hand_out_q, hand_out_d;
  logic [2:0]               pos_out_q, pos_out_d;

  logic                     load_edge;
  logic [2:0]               h;
  logic                     last_pos;
  logic                     fault;
  logic                     do_throw;
  ball_id_t                 throw_id;
  logic                     q_clear, q_shift, q_wr;
  logic [2:0]               q_idx;
  landing_slot_t            lander;
  logic                     q_occupied;

  assign load_edge = pattern_valid_in && !pv_q;
  assign h         = (int'(pos_q) < MAX_LEN) ? pat_q[pos_q] : 3'd0;
  assign last_pos  = (pos_q == len_q - 3'd1) || (int'(pos_q) >= MAX_LEN-1);
  assign q_idx     = h - 3'd1;

  landing_queue #(
    .DEPTH(MAX_HEIGHT)
  ) u_landing_queue (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .clear_in    (q_clear),
    .shift_in    (q_shift),
    .wr_en_in    (q_wr),
    .wr_idx_in   (q_idx),
    .wr_id_in    (throw_id),
    .head_out    (lander),
    .occupied_out(q_occupied)
  );

  always_comb begin
    state_d    = state_q;
    pv_d       = pattern_valid_in;
    pat_d      = pat_q;
    len_d      = len_q;
    balls_d    = balls_q;
    pos_d      = pos_q;
    hand_d     = hand_q;
    intro_d    = intro_q;
    valid_d    = 1'b0;
    ball_d     = ball_q;
    height_d   = height_q;
    hand_out_d = hand_out_q;
    pos_out_d  = pos_out_q;
    fault      = 1'b0;
    do_throw   = 1'b0;
    throw_id   = '0;
    q_clear    = 1'b0;
    q_shift    = 1'b0;
    q_wr       = 1'b0;

    // A load edge always takes priority over a coincident beat, in every state.
    if (load_edge) begin
      state_d = RUN;
      pat_d   = pattern_in;
      len_d   = pattern_length;
      balls_d = num_balls_in;
      pos_d   = '0;
      hand_d  = FIRST_HAND;
      intro_d = '0;
      q_clear = 1'b1;
    end else if (state_q == RUN && new_beat) begin
      q_shift = 1'b1;
      if (h == 3'd0) begin
        fault = lander.valid;
      end else if (int'(h) > MAX_HEIGHT) begin
        fault = 1'b1;
      end else if (lander.valid) begin
        do_throw = 1'b1;
        throw_id = lander.id;
      end else if (intro_q < balls_q) begin
        do_throw = 1'b1;
        throw_id = intro_q;
        intro_d  = intro_q + 3'd1;
      end else begin
        fault = 1'b1;
      end

      if (do_throw && q_occupied) begin
        fault = 1'b1;
      end

      q_wr       = do_throw && !fault;
      valid_d    = do_throw && !fault;
      if (do_throw && !fault) begin
        ball_d = throw_id;
      end
      height_d   = h;
      hand_out_d = hand_q;
      pos_out_d  = pos_q;
      hand_d     = !hand_q;
      pos_d      = last_pos ? 3'd0 : pos_q + 3'd1;
      state_d    = fault ? ERROR : RUN;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      pv_q       <= 1'b0;
      pat_q      <= '0;
      len_q      <= '0;
      balls_q    <= '0;
      pos_q      <= '0;
      hand_q     <= FIRST_HAND;
      intro_q    <= '0;
      valid_q    <= 1'b0;
      ball_q     <= '0;
      height_q   <= '0;
      hand_out_q <= 1'b0;
      pos_out_q  <= '0;
    end else begin
      state_q    <= state_d;
      pv_q       <= pv_d;
      pat_q      <= pat_d;
      len_q      <= len_d;
      balls_q    <= balls_d;
      pos_q      <= pos_d;
      hand_q     <= hand_d;
      intro_q    <= intro_d;
      valid_q    <= valid_d;
      ball_q     <= ball_d;
      height_q   <= height_d;
      hand_out_q <= hand_out_d;
      pos_out_q  <= pos_out_d;
    end
  end

`ifdef THROW_SCHED_STATS_EN
  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_edge) begin
      count_d = '0;
    end else if (valid_d && count_q != 16'hFFFF) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign throw_count_out = count_q;
`endif

  assign throw_valid_out  = valid_q;
  assign throw_ball_out   = ball_q;
  assign throw_height_out = height_q;
  assign throw_hand_out   = hand_out_q;
  assign pattern_pos_out  = pos_out_q;
  assign running_out      = (state_q == RUN);
  assign error_out        = (state_q == ERROR);

endmodule

// File: tb/tb_throw_scheduler.sv
// Scoreboard bench for throw_scheduler: expected throws are queued by the stimulus
// and popped by a monitor on every throw_valid_out pulse.
module tb_throw_scheduler;

  logic             clk_in = 1'b0;
  logic             rst_in = 1'b1;
  logic             new_beat = 1'b0;
  logic [6:0][2:0]  pattern_in = '0;
  logic [2:0]       pattern_length = '0;
  logic [2:0]       num_balls_in = '0;
  logic             pattern_valid_in = 1'b0;
  logic             throw_valid_out;
  logic [2:0]       throw_ball_out;
  logic [2:0]       throw_height_out;
  logic             throw_hand_out;
  logic [2:0]       pattern_pos_out;
  logic             running_out;
  logic             error_out;
`ifdef THROW_SCHED_STATS_EN
  logic [15:0]      throw_count_out;
`endif

  typedef struct packed {
    logic [2:0] ball;
    logic [2:0] height;
    logic       hand;
    logic [2:0] pos;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  throw_scheduler dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .new_beat        (new_beat),
    .pattern_in      (pattern_in),
    .pattern_length  (pattern_length),
    .num_balls_in    (num_balls_in),
    .pattern_valid_in(pattern_valid_in),
    .throw_valid_out (throw_valid_out),
    .throw_ball_out  (throw_ball_out),
    .throw_height_out(throw_height_out),
    .throw_hand_out  (throw_hand_out),
    .pattern_pos_out (pattern_pos_out),
    .running_out     (running_out),
`ifdef THROW_SCHED_STATS_EN
    .throw_count_out (throw_count_out),
`endif
    .error_out       (error_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (!rst_in && throw_valid_out) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_throw: actual ball=%0d height=%0d expected none",
                 throw_ball_out, throw_height_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ball", int'(throw_ball_out), int'(e.ball));
        check("height", int'(throw_height_out), int'(e.height));
        check("hand", int'(throw_hand_out), int'(e.hand));
        check("pos", int'(pattern_pos_out), int'(e.pos));
      end
    end
  end

  function automatic logic [6:0][2:0] pat3(input logic [2:0] a, input logic [2:0] b,
                                           input logic [2:0] c);
    logic [6:0][2:0] p;
    p    = '0;
    p[0] = a;
    p[1] = b;
    p[2] = c;
    return p;
  endfunction

  task automatic push(input int ball, input int height, input int hand, input int pos);
    exp_t e;
    e.ball   = 3'(ball);
    e.height = 3'(height);
    e.hand   = 1'(hand);
    e.pos    = 3'(pos);
    exp_q.push_back(e);
  endtask

  task automatic load(input logic [6:0][2:0] p, input int len, input int balls);
    @(negedge clk_in);
    pattern_in       = p;
    pattern_length   = 3'(len);
    num_balls_in     = 3'(balls);
    pattern_valid_in = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in);
    pattern_valid_in = 1'b0;
    @(negedge clk_in);
  endtask

  // Returns at the negedge where the beat's registered outputs are visible.
  task automatic beat();
    @(negedge clk_in);
    new_beat = 1'b1;
    @(negedge clk_in);
    new_beat = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    check("reset_outputs", int'({throw_valid_out, throw_ball_out, throw_height_out,
                                 throw_hand_out, pattern_pos_out}), 0);
    check("reset_running", int'(running_out), 0);
    check("reset_error", int'(error_out), 0);
    beat();
    check("idle_beat_ignored", int'(throw_valid_out), 0);

    // "3", 3 balls
    load(pat3(3'd3, 3'd0, 3'd0), 1, 3);
    check("load_running", int'(running_out), 1);
    for (int i = 0; i < 8; i++) begin
      push(i % 3, 3, i % 2, 0);
      beat();
    end

    // "441", 3 balls
    begin
      int balls[7] = '{0, 1, 2, 2, 0, 1, 1};
      int hts[7]   = '{4, 4, 1, 4, 4, 1, 4};
      load(pat3(3'd4, 3'd4, 3'd1), 3, 3);
      for (int i = 0; i < 7; i++) begin
        push(balls[i], hts[i], i % 2, i % 3);
        beat();
      end
    end

    // "60", 3 balls: throws only on even beats
    begin
      int balls60[4] = '{0, 1, 2, 0};
      load(pat3(3'd6, 3'd0, 3'd0), 2, 3);
      for (int i = 0; i < 7; i++) begin
        if (i % 2 == 0) push(balls60[i/2], 6, 0, 0);
        beat();
        if (i == 1) begin
          check("zero_beat_valid", int'(throw_valid_out), 0);
          check("zero_beat_hand", int'(throw_hand_out), 1);
          check("zero_beat_height", int'(throw_height_out), 0);
          check("zero_beat_pos", int'(pattern_pos_out), 1);
        end
      end
    end

    // "3" with only 2 balls: third beat has no ball to throw
    load(pat3(3'd3, 3'd0, 3'd0), 1, 2);
    push(0, 3, 0, 0);
    beat();
    push(1, 3, 1, 0);
    beat();
    beat();
    check("starve_valid", int'(throw_valid_out), 0);
    check("starve_error", int'(error_out), 1);
    check("starve_running", int'(running_out), 0);
    beat();
    check("error_sticky", int'(error_out), 1);
    load(pat3(3'd3, 3'd0, 3'd0), 1, 3);
    check("recover_error", int'(error_out), 0);
    check("recover_running", int'(running_out), 1);
    push(0, 3, 0, 0);
    beat();

    // reset in the middle of "441"
    load(pat3(3'd4, 3'd4, 3'd1), 3, 3);
    push(0, 4, 0, 0);
    beat();
    push(1, 4, 1, 1);
    beat();
    push(2, 1, 0, 2);
    beat();
    @(negedge clk_in);
    rst_in   = 1'b1;
    new_beat = 1'b1;
    @(negedge clk_in);
    rst_in   = 1'b0;
    new_beat = 1'b0;
    check("midrun_reset_outputs", int'({throw_valid_out, throw_ball_out, throw_height_out,
                                        throw_hand_out, pattern_pos_out}), 0);
    check("midrun_reset_running", int'(running_out), 0);
    check("midrun_reset_error", int'(error_out), 0);
    load(pat3(3'd4, 3'd4, 3'd1), 3, 3);
    push(0, 4, 0, 0);
    beat();
    push(1, 4, 1, 1);
    beat();
    push(2, 1, 0, 2);
    beat();
    push(2, 4, 1, 0);
    beat();

`ifdef THROW_SCHED_STATS_EN
    begin
      int balls60s[5] = '{0, 1, 2, 0, 1};
      load(pat3(3'd6, 3'd0, 3'd0), 2, 3);
      check("count_after_load", int'(throw_count_out), 0);
      for (int i = 0; i < 10; i++) begin
        if (i % 2 == 0) push(balls60s[i/2], 6, 0, 0);
        beat();
      end
      check("count_10_beats", int'(throw_count_out), 5);
      load(pat3(3'd6, 3'd0, 3'd0), 2, 3);
      check("count_reload", int'(throw_count_out), 0);
    end
`endif

    repeat (3) @(negedge clk_in);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
